// File: rtl/gradient_write_pkg.sv
// Shared types and default widths for the gradient write scheduler.
package gradient_write_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int VALUE_W_DEF = 16;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_PATH_A,
    SEL_EVICT
  } sel_e;

endpackage

// File: rtl/write_fifo.sv
// Synchronous FIFO holding {address,value} write entries; no pass-through when full.
module write_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Fullness comes from the registered count, so a pop never frees a slot for the same edge.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = storage[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      storage[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gradient_write_scheduler.sv
// Shares the memory write port between Path A and eviction, Path A first with a starvation bound.
module gradient_write_scheduler
  import gradient_write_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W_DEF,
  parameter int VALUE_WIDTH  = VALUE_W_DEF,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic        [ADDR_WIDTH-1:0]  path_a_address,
  input  logic signed [VALUE_WIDTH-1:0] path_a_value,
  input  logic                          path_a_valid,
  output logic                          path_a_ready,
  input  logic        [ADDR_WIDTH-1:0]  evict_address,
  input  logic signed [VALUE_WIDTH-1:0] evict_value,
  input  logic                          evict_valid,
  output logic                          evict_ready,
  output logic        [ADDR_WIDTH-1:0]  mem_address,
  output logic signed [VALUE_WIDTH-1:0] mem_value,
  output logic                          mem_valid,
  input  logic                          mem_ready,
  output logic                          starve_override
);

  localparam int EW = ADDR_WIDTH + VALUE_WIDTH;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [EW-1:0] a_dout;
  logic [EW-1:0] e_dout;
  logic [EW-1:0] head;
  logic          a_full;
  logic          a_empty;
  logic          e_full;
  logic          e_empty;
  logic          a_push;
  logic          e_push;
  logic          a_pop;
  logic          e_pop;
  logic          load;
  logic          starve_hit;
  logic [SW-1:0] starve_cnt;
  sel_e          sel;

  assign path_a_ready = !reset && !a_full;
  assign evict_ready  = !reset && !e_full;
  assign a_push       = path_a_valid && path_a_ready;
  assign e_push       = evict_valid && evict_ready;

  write_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clock (clock),
    .reset (reset),
    .push  (a_push),
    .pop   (a_pop),
    .din   ({path_a_address, path_a_value}),
    .dout  (a_dout),
    .full  (a_full),
    .empty (a_empty)
  );

  write_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo_e (
    .clock (clock),
    .reset (reset),
    .push  (e_push),
    .pop   (e_pop),
    .din   ({evict_address, evict_value}),
    .dout  (e_dout),
    .full  (e_full),
    .empty (e_empty)
  );

  assign load = (!mem_valid || mem_ready) && (!a_empty || !e_empty);

  always_comb begin
    sel        = SEL_NONE;
    starve_hit = 1'b0;
    if (load) begin
      if (!e_empty && (starve_cnt == SW'(STARVE_LIMIT))) begin
        sel        = SEL_EVICT;
        starve_hit = 1'b1;
      end else if (!a_empty) begin
        sel = SEL_PATH_A;
      end else begin
        sel = SEL_EVICT;
      end
    end
  end

  assign a_pop = (sel == SEL_PATH_A);
  assign e_pop = (sel == SEL_EVICT);
  assign head  = (sel == SEL_EVICT) ? e_dout : a_dout;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_address     <= '0;
      mem_value       <= '0;
      mem_valid       <= 1'b0;
      starve_cnt      <= '0;
      starve_override <= 1'b0;
    end else begin
      starve_override <= starve_hit;
      if (load) begin
        mem_address <= head[EW-1:VALUE_WIDTH];
        mem_value   <= head[VALUE_WIDTH-1:0];
        mem_valid   <= 1'b1;
        // Count only Path A wins that actually made an eviction entry wait.
        if (sel == SEL_PATH_A && !e_empty) begin
          if (starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end else if (sel == SEL_EVICT) begin
          starve_cnt <= '0;
        end
      end else if (mem_valid && mem_ready) begin
        mem_valid   <= 1'b0;
        mem_address <= '0;
        mem_value   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gradient_write_scheduler.sv
// Directed bench for gradient_write_scheduler: one task per scenario, hand-computed expectations.
module tb_gradient_write_scheduler;

  logic               clock = 1'b0;
  logic               reset;
  logic        [31:0] path_a_address;
  logic signed [15:0] path_a_value;
  logic               path_a_valid;
  logic               path_a_ready;
  logic        [31:0] evict_address;
  logic signed [15:0] evict_value;
  logic               evict_valid;
  logic               evict_ready;
  logic        [31:0] mem_address;
  logic signed [15:0] mem_value;
  logic               mem_valid;
  logic               mem_ready;
  logic               starve_override;

  int n_checks = 0;
  int n_fail   = 0;

  gradient_write_scheduler #(
    .ADDR_WIDTH(32), .VALUE_WIDTH(16), .FIFO_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .path_a_address  (path_a_address),
    .path_a_value    (path_a_value),
    .path_a_valid    (path_a_valid),
    .path_a_ready    (path_a_ready),
    .evict_address   (evict_address),
    .evict_value     (evict_value),
    .evict_valid     (evict_valid),
    .evict_ready     (evict_ready),
    .mem_address     (mem_address),
    .mem_value       (mem_value),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .starve_override (starve_override)
  );

  always #5 clock = ~clock;

  // Outputs are read 1 time unit after the rising edge; inputs change right after that.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    path_a_valid   = 1'b0;
    path_a_address = '0;
    path_a_value   = '0;
    evict_valid    = 1'b0;
    evict_address  = '0;
    evict_value    = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_ready = 1'b1;
    reset     = 1'b1;
    repeat (3) step();
    n_checks++;
    if (path_a_ready !== 1'b0 || evict_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got a=%b e=%b, expected 0 0", path_a_ready, evict_ready);
    end
    n_checks++;
    if (mem_valid !== 1'b0 || mem_address !== 32'h0 || mem_value !== 16'sh0 || starve_override !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b a=%h d=%h ov=%b, expected all 0",
               mem_valid, mem_address, mem_value, starve_override);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (path_a_ready !== 1'b1 || evict_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: got a=%b e=%b, expected 1 1", path_a_ready, evict_ready);
    end
  endtask

  task automatic test_single_push();
    path_a_valid   = 1'b1;
    path_a_address = 32'h100;
    path_a_value   = -16'sd5;
    step();
    idle_inputs();
    n_checks++;
    if (mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_bypass: got mem_valid=%b, expected 0", mem_valid);
    end
    step();
    n_checks++;
    if (mem_valid !== 1'b1 || mem_address !== 32'h100 || mem_value !== -16'sd5) begin
      n_fail++;
      $display("FAIL single_out: got v=%b a=%h d=%0d, expected 1 00000100 -5", mem_valid, mem_address, mem_value);
    end
    step();
    n_checks++;
    if (mem_valid !== 1'b0 || mem_address !== 32'h0) begin
      n_fail++;
      $display("FAIL single_drain: got v=%b a=%h, expected 0 00000000", mem_valid, mem_address);
    end
  endtask

  task automatic test_back_to_back();
    path_a_valid   = 1'b1;
    path_a_address = 32'h10;
    path_a_value   = 16'sd3;
    evict_valid    = 1'b1;
    evict_address  = 32'h20;
    evict_value    = -16'sd7;
    step();
    idle_inputs();
    step();
    n_checks++;
    if (mem_valid !== 1'b1 || mem_address !== 32'h10 || mem_value !== 16'sd3 || dut.starve_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b a=%h d=%0d cnt=%0d, expected 1 00000010 3 1",
               mem_valid, mem_address, mem_value, dut.starve_cnt);
    end
    step();
    n_checks++;
    if (mem_valid !== 1'b1 || mem_address !== 32'h20 || mem_value !== -16'sd7 || dut.starve_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b a=%h d=%0d cnt=%0d, expected 1 00000020 -7 0",
               mem_valid, mem_address, mem_value, dut.starve_cnt);
    end
    step();
    n_checks++;
    if (mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got mem_valid=%b, expected 0", mem_valid);
    end
  endtask

  task automatic test_starvation();
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic        exp_ov;
    mem_ready = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      path_a_valid   = (c <= 9);
      path_a_address = 32'h200 + 32'(c);
      path_a_value   = 16'(c);
      evict_valid    = (c == 0);
      evict_address  = 32'h99;
      evict_value    = 16'sd9;
      if (c <= 9) begin
        n_checks++;
        if (path_a_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL starve_ready c=%0d: got path_a_ready=%b, expected 1", c, path_a_ready);
        end
      end
      step();
      exp_ov    = 1'b0;
      exp_valid = 1'b1;
      exp_addr  = 32'h0;
      if (c == 0 || c == 12) exp_valid = 1'b0;
      else if (c <= 8) exp_addr = 32'h200 + 32'(c - 1);
      else if (c == 9) begin
        exp_addr = 32'h99;
        exp_ov   = 1'b1;
      end else exp_addr = 32'h200 + 32'(c - 2);
      n_checks++;
      if (mem_valid !== exp_valid || (exp_valid && mem_address !== exp_addr) || starve_override !== exp_ov) begin
        n_fail++;
        $display("FAIL starve c=%0d: got v=%b a=%h ov=%b, expected %b %h %b",
                 c, mem_valid, mem_address, starve_override, exp_valid, exp_addr, exp_ov);
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      path_a_valid   = 1'b1;
      path_a_address = 32'h300 + 32'(i);
      path_a_value   = 16'(i);
      n_checks++;
      if (path_a_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_ready i=%0d: got %b, expected 1", i, path_a_ready);
      end
      step();
    end
    path_a_address = 32'h305;
    n_checks++;
    if (path_a_ready !== 1'b0 || mem_valid !== 1'b1 || mem_address !== 32'h300) begin
      n_fail++;
      $display("FAIL bp_full: got ready=%b v=%b a=%h, expected 0 1 00000300", path_a_ready, mem_valid, mem_address);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (mem_valid !== 1'b1 || mem_address !== 32'h300 || mem_value !== 16'sd0 || path_a_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold k=%0d: got v=%b a=%h d=%0d ready=%b, expected 1 00000300 0 0",
                 k, mem_valid, mem_address, mem_value, path_a_ready);
      end
    end
    idle_inputs();
    mem_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      n_checks++;
      if (mem_valid !== 1'b1 || mem_address !== 32'h300 + 32'(i)) begin
        n_fail++;
        $display("FAIL bp_drain i=%0d: got v=%b a=%h, expected 1 %h", i, mem_valid, mem_address, 32'h300 + 32'(i));
      end
    end
    step();
    n_checks++;
    if (mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: got mem_valid=%b, expected 0", mem_valid);
    end
  endtask

  task automatic test_full_pop_push();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      path_a_valid   = 1'b1;
      path_a_address = 32'h400 + 32'(i);
      path_a_value   = 16'(i);
      step();
    end
    path_a_address = 32'h405;
    mem_ready      = 1'b1;
    n_checks++;
    if (path_a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fpp_refuse: got path_a_ready=%b, expected 0", path_a_ready);
    end
    step();
    n_checks++;
    if (mem_address !== 32'h401 || path_a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fpp_after_pop: got a=%h ready=%b, expected 00000401 1", mem_address, path_a_ready);
    end
    step();
    idle_inputs();
    for (int i = 2; i <= 5; i++) begin
      if (i > 2) step();
      n_checks++;
      if (mem_valid !== 1'b1 || mem_address !== 32'h400 + 32'(i)) begin
        n_fail++;
        $display("FAIL fpp_drain i=%0d: got v=%b a=%h, expected 1 %h", i, mem_valid, mem_address, 32'h400 + 32'(i));
      end
    end
    step();
    n_checks++;
    if (mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fpp_once: got mem_valid=%b a=%h, expected 0", mem_valid, mem_address);
    end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      path_a_valid   = 1'b1;
      path_a_address = 32'h500 + 32'(i);
      path_a_value   = 16'(i);
      evict_valid    = (i < 3);
      evict_address  = 32'h600 + 32'(i);
      evict_value    = 16'(i);
      step();
    end
    idle_inputs();
    n_checks++;
    if (mem_valid !== 1'b1 || mem_address !== 32'h500) begin
      n_fail++;
      $display("FAIL rmid_setup: got v=%b a=%h, expected 1 00000500", mem_valid, mem_address);
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (mem_valid !== 1'b0 || mem_address !== 32'h0 || mem_value !== 16'sh0 ||
        path_a_ready !== 1'b0 || evict_ready !== 1'b0 || starve_override !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_reset: got v=%b a=%h d=%h ra=%b re=%b ov=%b, expected all 0",
               mem_valid, mem_address, mem_value, path_a_ready, evict_ready, starve_override);
    end
    reset     = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (mem_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_stale k=%0d: got v=%b a=%h, expected 0", k, mem_valid, mem_address);
      end
    end
    evict_valid   = 1'b1;
    evict_address = 32'h777;
    evict_value   = 16'sd1;
    step();
    idle_inputs();
    step();
    n_checks++;
    if (mem_valid !== 1'b1 || mem_address !== 32'h777 || dut.starve_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL rmid_fresh: got v=%b a=%h cnt=%0d, expected 1 00000777 0",
               mem_valid, mem_address, dut.starve_cnt);
    end
    step();
  endtask

  initial begin
    idle_inputs();
    reset     = 1'b1;
    mem_ready = 1'b1;
    test_reset();
    test_single_push();
    test_back_to_back();
    test_starvation();
    test_backpressure();
    test_full_pop_push();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
